// File: rtl/instr_register_pipe.sv
// instr_register_pipe: pipelined instruction register file.
// Stage 1 captures the incoming instruction and its target entry.
// Stage 2 computes the signed ALU result and writes the entry on the next edge.
// Each entry has a valid bit. The block keeps a count of valid entries and an
// auto-incrementing write pointer, and supports a synchronous flush.
// Optional feature macro: IREG_BYPASS_EN forwards the stage-1 instruction and
// its computed result to the read port when the read address matches the
// entry being written.

package instr_register_pkg;
   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;
endpackage

module instr_register_pipe
   import instr_register_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int RES_W  = 2 * DATA_W,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load_en,
   input  opcode_t                  opcode,
   input  logic signed [DATA_W-1:0] operand_a,
   input  logic signed [DATA_W-1:0] operand_b,
   input  logic        [PTR_W-1:0]  write_pointer,
   input  logic                     auto_wp,
   input  logic                     clear,
   input  logic        [PTR_W-1:0]  read_pointer,
   output opcode_t                  rd_opcode,
   output logic signed [DATA_W-1:0] rd_operand_a,
   output logic signed [DATA_W-1:0] rd_operand_b,
   output logic signed [RES_W-1:0]  rd_result,
   output logic                     rd_div0,
   output logic                     rd_valid,
   output logic        [CNT_W-1:0]  valid_cnt,
   output logic        [PTR_W-1:0]  wp_cnt,
   output logic                     busy
);

   typedef struct packed {
      opcode_t                  opc;
      logic signed [DATA_W-1:0] op_a;
      logic signed [DATA_W-1:0] op_b;
      logic signed [RES_W-1:0]  res;
      logic                     div0;
   } entry_t;

   // Stage-1 registers
   logic                     s1_valid;
   opcode_t                  s1_opc;
   logic signed [DATA_W-1:0] s1_a;
   logic signed [DATA_W-1:0] s1_b;
   logic        [PTR_W-1:0]  s1_addr;

   // Execute-stage combinational values
   logic signed [RES_W-1:0]  a_ext;
   logic signed [RES_W-1:0]  b_ext;
   logic signed [RES_W-1:0]  div_b;
   logic                     b_zero;
   logic signed [RES_W-1:0]  alu_res;
   logic                     alu_div0;
   entry_t                   wr_entry;
   logic                     wr_ok;

   // Register file and per-entry valid bits
   entry_t                   mem [DEPTH];
   logic        [DEPTH-1:0]  valid_q;

   entry_t                   rd_entry;
   logic                     rd_in_range;

   assign busy = s1_valid;

   // Capture stage: latch the instruction and its target entry when a load is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of the order of the statements.
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_opc   <= ZERO;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_addr  <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= load_en;
         if (load_en) begin
            s1_opc  <= opcode;
            s1_a    <= operand_a;
            s1_b    <= operand_b;
            s1_addr <= auto_wp ? wp_cnt : write_pointer;
         end
      end
   end

   // Auto write pointer: advances on each auto-addressed load and wraps at DEPTH-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_cnt <= '0;
      end else if (clear) begin
         wp_cnt <= '0;
      end else if (load_en && auto_wp) begin
         wp_cnt <= (wp_cnt == PTR_W'(DEPTH - 1)) ? '0 : wp_cnt + PTR_W'(1);
      end
   end

   // Execute stage: signed ALU on the captured operands, in double-width arithmetic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value held and infer a latch.
      alu_res  = '0;
      alu_div0 = 1'b0;
      a_ext    = RES_W'(s1_a);
      b_ext    = RES_W'(s1_b);
      b_zero   = (s1_b == '0);
      // The divisor is never zero, even on a path whose result is discarded
      div_b    = b_zero ? RES_W'(1) : b_ext;
      case (s1_opc)
         ZERO:  alu_res = '0;
         PASSA: alu_res = a_ext;
         PASSB: alu_res = b_ext;
         ADD:   alu_res = a_ext + b_ext;
         SUB:   alu_res = a_ext - b_ext;
         MULT:  alu_res = a_ext * b_ext;
         DIV: begin
            if (b_zero) alu_div0 = 1'b1;
            else        alu_res  = a_ext / div_b;
         end
         MOD: begin
            if (b_zero) alu_div0 = 1'b1;
            else        alu_res  = a_ext % div_b;
         end
         default: alu_res = '0;
      endcase
      wr_entry = '{opc: s1_opc, op_a: s1_a, op_b: s1_b, res: alu_res, div0: alu_div0};
      // Targets past the last entry (possible when DEPTH is not a power of 2) are dropped
      wr_ok    = s1_valid && (int'(s1_addr) < DEPTH);
   end

   // Write stage: commit the entry, set its valid bit and count newly valid entries
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the array is reset on purpose, because every read output
         // must be zero during and right after reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '{opc: ZERO, default: '0};
         end
         valid_q   <= '0;
         valid_cnt <= '0;
      end else if (clear) begin
         // Flush drops the in-flight write; entry data is intentionally kept
         valid_q   <= '0;
         valid_cnt <= '0;
      end else if (wr_ok) begin
         mem[s1_addr]     <= wr_entry;
         valid_q[s1_addr] <= 1'b1;
         if (!valid_q[s1_addr]) begin
            valid_cnt <= valid_cnt + CNT_W'(1);
         end
      end
   end

   // Read port: combinational from the array, zero for addresses past the last entry
   always_comb begin
      rd_entry    = '0;
      rd_valid    = 1'b0;
      rd_in_range = (int'(read_pointer) < DEPTH);
      if (rd_in_range) begin
         rd_entry = mem[read_pointer];
         rd_valid = valid_q[read_pointer];
      end
`ifdef IREG_BYPASS_EN
      // Forward the entry that the next edge will write, so it is visible right after capture
      if (rd_in_range && s1_valid && (s1_addr == read_pointer)) begin
         rd_entry = wr_entry;
         rd_valid = 1'b1;
      end
`else
      // No forwarding: a read of the entry being written returns its old content
`endif
      rd_opcode    = rd_entry.opc;
      rd_operand_a = rd_entry.op_a;
      rd_operand_b = rd_entry.op_b;
      rd_result    = rd_entry.res;
      rd_div0      = rd_entry.div0;
   end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed, table-driven bench for instr_register_pipe (DATA_W=8, DEPTH=6).
// Expected values are computed by hand from the intended arithmetic.
// If IREG_BYPASS_EN is defined, the bench expects forwarded values right after capture.

module tb_instr_register_pipe;
   import instr_register_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 6;
   localparam int PTR_W  = 3;
   localparam int RES_W  = 16;
   localparam int CNT_W  = 3;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     load_en;
   opcode_t                  opcode;
   logic signed [DATA_W-1:0] operand_a;
   logic signed [DATA_W-1:0] operand_b;
   logic        [PTR_W-1:0]  write_pointer;
   logic                     auto_wp;
   logic                     clear;
   logic        [PTR_W-1:0]  read_pointer;
   opcode_t                  rd_opcode;
   logic signed [DATA_W-1:0] rd_operand_a;
   logic signed [DATA_W-1:0] rd_operand_b;
   logic signed [RES_W-1:0]  rd_result;
   logic                     rd_div0;
   logic                     rd_valid;
   logic        [CNT_W-1:0]  valid_cnt;
   logic        [PTR_W-1:0]  wp_cnt;
   logic                     busy;

   int n_chk = 0;
   int n_err = 0;

   instr_register_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_en      (load_en),
      .opcode       (opcode),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .write_pointer(write_pointer),
      .auto_wp      (auto_wp),
      .clear        (clear),
      .read_pointer (read_pointer),
      .rd_opcode    (rd_opcode),
      .rd_operand_a (rd_operand_a),
      .rd_operand_b (rd_operand_b),
      .rd_result    (rd_result),
      .rd_div0      (rd_div0),
      .rd_valid     (rd_valid),
      .valid_cnt    (valid_cnt),
      .wp_cnt       (wp_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      opcode_t            opc;
      logic signed [7:0]  a;
      logic signed [7:0]  b;
      logic        [2:0]  addr;
      logic signed [15:0] res;
      logic               div0;
      logic        [2:0]  vcnt;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input opcode_t o, input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic [2:0] wp, input logic aw);
      load_en       = 1'b1;
      opcode        = o;
      operand_a     = a;
      operand_b     = b;
      write_pointer = wp;
      auto_wp       = aw;
   endtask

   task automatic idle();
      load_en = 1'b0;
      auto_wp = 1'b0;
   endtask

   initial begin
      logic signed [15:0] auto_exp [6];

      vecs[0]  = '{ADD,   -8'sd5,   8'sd7,   3'd3, 16'sd2,      1'b0, 3'd1};
      vecs[1]  = '{MULT,  8'sh80,   8'sh80,  3'd0, 16'sd16384,  1'b0, 3'd2};
      vecs[2]  = '{DIV,   -8'sd7,   8'sd2,   3'd1, -16'sd3,     1'b0, 3'd3};
      vecs[3]  = '{MOD,   -8'sd7,   8'sd2,   3'd2, -16'sd1,     1'b0, 3'd4};
      vecs[4]  = '{DIV,   8'sd9,    8'sd0,   3'd4, 16'sd0,      1'b1, 3'd5};
      vecs[5]  = '{MOD,   8'sd5,    8'sd0,   3'd5, 16'sd0,      1'b1, 3'd6};
      vecs[6]  = '{SUB,   8'sh80,   8'sd127, 3'd0, -16'sd255,   1'b0, 3'd6};
      vecs[7]  = '{PASSB, 8'sd3,    -8'sd9,  3'd1, -16'sd9,     1'b0, 3'd6};
      vecs[8]  = '{MULT,  8'sd127,  8'sh80,  3'd2, -16'sd16256, 1'b0, 3'd6};
      vecs[9]  = '{ZERO,  8'sd55,   8'sd66,  3'd3, 16'sd0,      1'b0, 3'd6};
      vecs[10] = '{DIV,   8'sh80,   -8'sd1,  3'd4, 16'sd128,    1'b0, 3'd6};
      vecs[11] = '{MOD,   8'sd7,    -8'sd3,  3'd5, 16'sd1,      1'b0, 3'd6};
      vecs[12] = '{opcode_t'(4'hC), 8'sd3, 8'sd4, 3'd0, 16'sd0, 1'b0, 3'd6};

      reset_n       = 1'b0;
      load_en       = 1'b0;
      opcode        = ZERO;
      operand_a     = '0;
      operand_b     = '0;
      write_pointer = '0;
      auto_wp       = 1'b0;
      clear         = 1'b0;
      read_pointer  = '0;

      // Reset state: every address reads zero, counters idle
      repeat (2) @(posedge clk);
      #1;
      for (int p = 0; p < 8; p++) begin
         read_pointer = 3'(p);
         #1;
         check($sformatf("reset read %0d", p),
               {rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div0, rd_valid}, 0);
      end
      check("reset valid_cnt", valid_cnt, 0);
      check("reset wp_cnt", wp_cnt, 0);
      check("reset busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset in the middle of a load: instruction lost, nothing written
      load(PASSA, 8'sd9, 8'sd0, 3'd2, 1'b0);
      step();
      check("midreset busy before", busy, 1);
      idle();
      #2 reset_n = 1'b0;
      #1 check("midreset busy", busy, 0);
      #1 reset_n = 1'b1;
      step();
      read_pointer = 3'd2;
      #1;
      check("midreset entry2", {rd_opcode, rd_operand_a, rd_result, rd_valid}, 0);
      check("midreset valid_cnt", valid_cnt, 0);

      // Table of single loads: write, then read back one edge later
      for (int i = 0; i < 13; i++) begin
         load(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].addr, 1'b0);
         read_pointer = vecs[i].addr;
         step();
         check($sformatf("vec%0d busy", i), busy, 1);
         idle();
         step();
         check($sformatf("vec%0d busy after", i), busy, 0);
         check($sformatf("vec%0d result", i), rd_result, vecs[i].res);
         check($sformatf("vec%0d div0", i), rd_div0, vecs[i].div0);
         check($sformatf("vec%0d fields", i), {rd_opcode, rd_operand_a, rd_operand_b},
               {vecs[i].opc, vecs[i].a, vecs[i].b});
         check($sformatf("vec%0d valid", i), rd_valid, 1);
         check($sformatf("vec%0d valid_cnt", i), valid_cnt, vecs[i].vcnt);
      end

      // Out-of-range write address is dropped; out-of-range reads are zero
      load(PASSA, 8'sd99, 8'sd0, 3'd6, 1'b0);
      step();
      idle();
      step();
      check("oor valid_cnt", valid_cnt, 6);
      for (int p = 6; p < 8; p++) begin
         read_pointer = 3'(p);
         #1;
         check($sformatf("oor read %0d", p),
               {rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div0, rd_valid}, 0);
      end

      // Same-cycle read of the entry being written
      load(PASSA, 8'sd42, 8'sd0, 3'd5, 1'b0);
      read_pointer = 3'd5;
      step();
      idle();
`ifdef IREG_BYPASS_EN
      check("bypass early result", rd_result, 42);
      check("bypass early valid", rd_valid, 1);
`else
      check("nobypass old result", rd_result, 1);
`endif
      step();
      check("bypass late result", rd_result, 42);

      // Back-to-back loads to the same entry: the later one wins one edge later
      load(ADD, 8'sd1, 8'sd2, 3'd0, 1'b0);
      read_pointer = 3'd0;
      step();
      load(SUB, 8'sd10, 8'sd3, 3'd0, 1'b0);
      step();
      idle();
`ifdef IREG_BYPASS_EN
      check("b2b mid result", rd_result, 7);
`else
      check("b2b mid result", rd_result, 3);
`endif
      step();
      check("b2b final result", rd_result, 7);
      check("b2b valid_cnt", valid_cnt, 6);

      // Plain flush: valid state cleared, data kept
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear valid_cnt", valid_cnt, 0);
      check("clear wp_cnt", wp_cnt, 0);
      check("clear rd_valid", rd_valid, 0);
      check("clear data kept", rd_result, 7);

      // Auto write pointer: 8 loads wrap over 6 entries
      for (int i = 0; i < 8; i++) begin
         load(PASSA, 8'(10 + i), 8'sd0, 3'd7, 1'b1);
         step();
         check($sformatf("auto wp_cnt %0d", i), wp_cnt, (i + 1) % 6);
      end
      idle();
      step();
      check("auto valid_cnt", valid_cnt, 6);
      check("auto wp_cnt final", wp_cnt, 2);
      auto_exp = '{16'sd16, 16'sd17, 16'sd12, 16'sd13, 16'sd14, 16'sd15};
      for (int p = 0; p < 6; p++) begin
         read_pointer = 3'(p);
         #1;
         check($sformatf("auto entry %0d", p), {rd_valid, rd_result}, {1'b1, auto_exp[p]});
      end

      // Flush with an instruction in flight and a load in the same cycle
      load(PASSA, 8'sd77, 8'sd0, 3'd3, 1'b0);
      step();
      load(PASSA, 8'sd88, 8'sd0, 3'd4, 1'b1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      idle();
      check("flush valid_cnt", valid_cnt, 0);
      check("flush wp_cnt", wp_cnt, 0);
      check("flush busy", busy, 0);
      step();
      for (int p = 0; p < 6; p++) begin
         read_pointer = 3'(p);
         #1;
         check($sformatf("flush valid %0d", p), rd_valid, 0);
      end
      read_pointer = 3'd3;
      #1 check("flush entry3 kept", rd_result, 13);
      read_pointer = 3'd4;
      #1 check("flush entry4 kept", rd_result, 14);
      check("flush valid_cnt later", valid_cnt, 0);
      check("flush wp_cnt later", wp_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_register_pipe.md
# instr_register_pipe

Parametrised, pipelined successor to the lab instruction register. It accepts one instruction per cycle, with opcode and two signed operands. It computes the ALU result in a registered execute stage, then writes opcode, operands, result and a divide-by-zero flag into a DEPTH-entry register file. It adds per-entry valid tracking, an auto-incrementing write pointer mode and a synchronous flush, and sits between the test-bench interface and the checker as the DUT.

## Interface
- DATA_W, 32: operand width, signed, ≥2
- DEPTH, 32: register-file entries, ≥2, need not be a power of 2
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridden)
- RES_W, 2*DATA_W: result width (derived)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_en  in  1  accept instruction this cycle
- opcode  in  opcode_t  ZERO/PASSA/PASSB/ADD/SUB/MULT/DIV/MOD (instr_register_pkg encoding)
- operand_a, operand_b  in  DATA_W  signed operands
- write_pointer  in  PTR_W  target entry when auto_wp=0
- auto_wp  in  1  1: use internal write counter instead of write_pointer
- clear  in  1  synchronous flush of valid bits, counter and pipeline
- read_pointer  in  PTR_W  combinational read address
- rd_opcode / rd_operand_a / rd_operand_b / rd_result  out  opcode_t / DATA_W / DATA_W / RES_W  entry fields
- rd_div0  out  1  entry's divide-by-zero flag
- rd_valid  out  1  entry written since last reset/clear
- valid_cnt  out  $clog2(DEPTH+1)  number of valid entries
- wp_cnt  out  PTR_W  internal auto write counter
- busy  out  1  execute stage holds an instruction

## Operation
- Stage 1 (capture): on an edge with load_en=1 and clear=0, register opcode, operands and target address. The target is wp_cnt if auto_wp=1, else write_pointer. Set stage valid.
- Stage 2 (execute/write): from the stage-1 registers, compute the result in RES_W signed arithmetic and write the full entry on the next edge. Set the entry's valid bit.
- Results:
  - ZERO → 0.
  - PASSA/PASSB → sign-extended operand.
  - ADD/SUB → sign-extended sum or difference (no overflow possible).
  - MULT → full 2W product.
  - DIV → truncates toward zero.
  - MOD → takes the sign of the dividend.
  - Undefined opcode → 0.
- Divide by zero: DIV or MOD with operand_b=0 writes result 0 and div0=1. div0=0 otherwise.
- wp_cnt increments on each accepted load with auto_wp=1 and wraps from DEPTH-1 to 0. Loads with auto_wp=0 leave it unchanged.
- valid_cnt increments only when a write targets a currently invalid entry. Rewriting a valid entry leaves it unchanged.
- Write address ≥ DEPTH (non-power-of-2 DEPTH): write is dropped, no flags change.
- Read address ≥ DEPTH: all rd_* outputs are 0 and rd_valid=0.
- clear has priority:
  - Clears all valid bits, valid_cnt, wp_cnt and stage valid on the edge.
  - An in-flight stage-2 write is discarded.
  - A load_en in the same cycle is ignored.
  - Entry data is not zeroed.
- Back-to-back loads to the same address: the later one wins, one cycle after the earlier.

## Timing
- Reset (async assert, sync-safe release) sets:
  - all entries to '{opc:ZERO, default:0}, including div0;
  - all valid bits, valid_cnt, wp_cnt, busy and stage valid to 0.
- As a result, all rd_* outputs are 0 during reset.
- Throughput: one load per cycle, no backpressure.
- Latency: load_en sampled at edge N; entry written and visible on rd_* at edge N+1.
- busy=1 for the cycle after each accepted load.
- Read is combinational from the array. A same-cycle read of the entry being written returns old content unless bypass is enabled.
- Reset mid-pipeline: the in-flight instruction is lost and no write occurs.

## Configuration
- IREG_BYPASS_EN defined: when stage valid=1 and its address equals read_pointer, rd_* show the stage-1 fields plus the combinationally computed result/div0, with rd_valid=1. Effective read latency is 0 cycles after the capture edge.
- IREG_BYPASS_EN undefined: no forwarding; read path is the array only.

## Test plan
- Reset, then read all entries → every rd_* = 0, valid_cnt=0. Assert reset_n mid-load → entry unchanged, busy=0.
- Load ADD a=-5 b=7 to wp=3, read_pointer=3 → rd_result=2 one edge after capture, rd_valid=1, valid_cnt=1.
- DATA_W=8: MULT a=-128 b=-128 → rd_result=16384. DIV a=-7 b=2 → -3. MOD a=-7 b=2 → -1. DIV a=9 b=0 → result 0, rd_div0=1.
- auto_wp=1, DEPTH=4, 6 consecutive loads → entries 0..3 then 0,1 rewritten. wp_cnt=2, valid_cnt=4.
- clear asserted with load_en and one instruction in flight → valid_cnt=0, wp_cnt=0, no entry written, rd_valid=0 everywhere.
- Bypass: load PASSA a=42 to entry 5 with read_pointer=5 → with IREG_BYPASS_EN, rd_result=42 right after the capture edge; without it, rd_result=42 one edge later.
